// File: rtl/ines_pkg.sv
// Shared types and constants for the iNES cartridge loader.
package ines_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_TRN  = 3'd2,
    ST_PRG  = 3'd3,
    ST_CHR  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } ines_state_t;

  localparam logic [7:0] MAGIC_0 = 8'h4E;  // 'N'
  localparam logic [7:0] MAGIC_1 = 8'h45;  // 'E'
  localparam logic [7:0] MAGIC_2 = 8'h53;  // 'S'
  localparam logic [7:0] MAGIC_3 = 8'h1A;  // EOF

  localparam int HDR_LEN        = 16;
  localparam int TRAINER_LEN    = 512;
  localparam int PRG_BANK_SHIFT = 14;
  localparam int CHR_BANK_SHIFT = 13;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return MAGIC_0;
      2'd1:    return MAGIC_1;
      2'd2:    return MAGIC_2;
      default: return MAGIC_3;
    endcase
  endfunction

endpackage

// File: rtl/ines_hdr_parse.sv
// iNES header decode: magic compare, bank-count / flag latches and size validation.
// INES_TRAINER_SKIP_EN: when undefined, a header with the trainer flag set is rejected.
module ines_hdr_parse
  import ines_pkg::*;
#(
  parameter int PRG_ADDR_W = 15,
  parameter int CHR_ADDR_W = 13
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       i_clear,
  input  logic       i_hdr_we,
  input  logic [3:0] i_idx,
  input  logic [7:0] i_data,
  output logic       o_magic_bad,
  output logic       o_hdr_bad,
  output logic       o_use_trn,
  output logic       o_mirror_v,
  output logic [7:0] o_prg_cnt,
  output logic [7:0] o_chr_cnt
);

  localparam logic [8:0] PRG_MAX = 9'(1 << (PRG_ADDR_W - PRG_BANK_SHIFT));
  localparam logic [8:0] CHR_MAX = 9'(1 << (CHR_ADDR_W - CHR_BANK_SHIFT));

  logic [7:0] r_prg_cnt;
  logic [7:0] r_chr_cnt;
  logic       r_trainer;
  logic       r_mirror_v;
  logic       w_size_bad;

  // Only meaningful on the accepting cycle; the top gates it with the handshake.
  assign o_magic_bad = (i_idx[3:2] == 2'b00) && (i_data != magic_byte(i_idx[1:0]));

  assign w_size_bad = (r_prg_cnt == 8'd0) ||
                      ({1'b0, r_prg_cnt} > PRG_MAX) ||
                      ({1'b0, r_chr_cnt} > CHR_MAX);

`ifdef INES_TRAINER_SKIP_EN
  assign o_hdr_bad = w_size_bad;
  assign o_use_trn = r_trainer;
`else
  assign o_hdr_bad = w_size_bad | r_trainer;
  assign o_use_trn = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_prg_cnt  <= 8'd0;
      r_chr_cnt  <= 8'd0;
      r_trainer  <= 1'b0;
      r_mirror_v <= 1'b0;
    end else if (i_clear) begin
      r_prg_cnt <= 8'd0;
      r_chr_cnt <= 8'd0;
      r_trainer <= 1'b0;
    end else if (i_hdr_we) begin
      case (i_idx)
        4'd4: r_prg_cnt <= i_data;
        4'd5: r_chr_cnt <= i_data;
        4'd6: begin
          r_mirror_v <= i_data[0];
          r_trainer  <= i_data[2];
        end
        default: ;
      endcase
    end
  end

  assign o_prg_cnt  = r_prg_cnt;
  assign o_chr_cnt  = r_chr_cnt;
  assign o_mirror_v = r_mirror_v;

endmodule

// File: rtl/ines_loader.sv
// iNES ROM loader: streams a byte image into cart PRG/CHR RAM and holds the console in reset meanwhile.
// INES_TRAINER_SKIP_EN: when defined, a 512-byte trainer after the header is skipped instead of rejected.
module ines_loader
  import ines_pkg::*;
#(
  parameter int PRG_ADDR_W = 15,
  parameter int CHR_ADDR_W = 13
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [7:0]            rx_data_in,
  input  logic                  rx_valid_in,
  output logic                  rx_ready_out,
  output logic                  prg_wr_en_out,
  output logic [PRG_ADDR_W-1:0] prg_wr_a_out,
  output logic                  chr_wr_en_out,
  output logic [CHR_ADDR_W-1:0] chr_wr_a_out,
  output logic [7:0]            wr_d_out,
  output logic                  mirror_v_out,
  output logic                  cart_rst_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output ines_state_t           dbg_state_out
);

  ines_state_t           r_state;
  logic [15:0]           r_cnt;
  logic                  r_prg_wr_en;
  logic                  r_chr_wr_en;
  logic [PRG_ADDR_W-1:0] r_prg_a;
  logic [CHR_ADDR_W-1:0] r_chr_a;
  logic [7:0]            r_wr_d;
  logic                  r_cart_rst;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic        w_ready;
  logic        w_acc;
  logic        w_start_go;
  logic        w_magic_bad;
  logic        w_hdr_bad;
  logic        w_use_trn;
  logic        w_mirror_v;
  logic [7:0]  w_prg_cnt;
  logic [7:0]  w_chr_cnt;
  logic [21:0] w_prg_end;
  logic [20:0] w_chr_end;
  logic        w_hdr_last;
  logic        w_prg_last;
  logic        w_chr_last;

  // Stream handshake: a byte transfers on a rising edge where rx_valid_in && rx_ready_out;
  // ready depends only on state, so the source may hold valid high and stream one byte per cycle.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_HDR, ST_TRN, ST_PRG, ST_CHR: w_ready = 1'b1;
      default:                        w_ready = 1'b0;
    endcase
  end

  assign w_acc      = rx_valid_in && w_ready;
  assign w_start_go = start_in &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

  assign w_prg_end  = ({14'd0, w_prg_cnt} << PRG_BANK_SHIFT) - 22'd1;
  assign w_chr_end  = ({13'd0, w_chr_cnt} << CHR_BANK_SHIFT) - 21'd1;
  assign w_hdr_last = (r_cnt[3:0] == 4'(HDR_LEN - 1));
  assign w_prg_last = ({6'd0, r_cnt} == w_prg_end);
  assign w_chr_last = ({5'd0, r_cnt} == w_chr_end);

`ifdef INES_TRAINER_SKIP_EN
  logic w_trn_last;
  assign w_trn_last = (r_cnt == 16'(TRAINER_LEN - 1));
`endif

  ines_hdr_parse #(
    .PRG_ADDR_W (PRG_ADDR_W),
    .CHR_ADDR_W (CHR_ADDR_W)
  ) u_hdr (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .i_clear     (w_start_go),
    .i_hdr_we    (w_acc && (r_state == ST_HDR)),
    .i_idx       (r_cnt[3:0]),
    .i_data      (rx_data_in),
    .o_magic_bad (w_magic_bad),
    .o_hdr_bad   (w_hdr_bad),
    .o_use_trn   (w_use_trn),
    .o_mirror_v  (w_mirror_v),
    .o_prg_cnt   (w_prg_cnt),
    .o_chr_cnt   (w_chr_cnt)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_prg_wr_en <= 1'b0;
      r_chr_wr_en <= 1'b0;
      r_prg_a     <= '0;
      r_chr_a     <= '0;
      r_wr_d      <= 8'd0;
      r_cart_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_prg_wr_en <= 1'b0;
      r_chr_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_start_go) begin
            r_state    <= ST_HDR;
            r_cnt      <= 16'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cart_rst <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_HDR: begin
          if (w_acc) begin
            if (w_magic_bad) begin
              r_state <= ST_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else if (w_hdr_last) begin
              r_cnt <= 16'd0;
              if (w_hdr_bad) begin
                r_state <= ST_ERR;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
              end else begin
                r_state <= w_use_trn ? ST_TRN : ST_PRG;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
`ifdef INES_TRAINER_SKIP_EN
        ST_TRN: begin
          if (w_acc) begin
            if (w_trn_last) begin
              r_cnt   <= 16'd0;
              r_state <= ST_PRG;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
`endif
        ST_PRG: begin
          if (w_acc) begin
            r_prg_wr_en <= 1'b1;
            r_prg_a     <= r_cnt[PRG_ADDR_W-1:0];
            r_wr_d      <= rx_data_in;
            if (w_prg_last) begin
              r_cnt <= 16'd0;
              // CHR count 0 means the cart uses CHR RAM: nothing to stream.
              if (w_chr_cnt == 8'd0) begin
                r_state    <= ST_DONE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_cart_rst <= 1'b0;
              end else begin
                r_state <= ST_CHR;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        ST_CHR: begin
          if (w_acc) begin
            r_chr_wr_en <= 1'b1;
            r_chr_a     <= r_cnt[CHR_ADDR_W-1:0];
            r_wr_d      <= rx_data_in;
            if (w_chr_last) begin
              r_cnt      <= 16'd0;
              r_state    <= ST_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cart_rst <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_ready_out  = w_ready;
  assign prg_wr_en_out = r_prg_wr_en;
  assign prg_wr_a_out  = r_prg_a;
  assign chr_wr_en_out = r_chr_wr_en;
  assign chr_wr_a_out  = r_chr_a;
  assign wr_d_out      = r_wr_d;
  assign mirror_v_out  = w_mirror_v;
  assign cart_rst_out  = r_cart_rst;
  assign busy_out      = r_busy;
  assign done_out      = r_done;
  assign error_out     = r_err;
  assign dbg_state_out = r_state;

endmodule

// File: tb/tb_ines_loader.sv
// Bench for ines_loader: table of header variants, random image bodies, reference write list per load.
module tb_ines_loader;
  import ines_pkg::*;

  localparam int PRG_W = 15;
  localparam int CHR_W = 13;
`ifdef INES_TRAINER_SKIP_EN
  localparam bit TRN_EN = 1'b1;
`else
  localparam bit TRN_EN = 1'b0;
`endif

  logic             clk_in;
  logic             rst_n_in;
  logic             start_in;
  logic [7:0]       rx_data_in;
  logic             rx_valid_in;
  logic             rx_ready_out;
  logic             prg_wr_en_out;
  logic [PRG_W-1:0] prg_wr_a_out;
  logic             chr_wr_en_out;
  logic [CHR_W-1:0] chr_wr_a_out;
  logic [7:0]       wr_d_out;
  logic             mirror_v_out;
  logic             cart_rst_out;
  logic             busy_out;
  logic             done_out;
  logic             error_out;
  ines_state_t      dbg_state_out;

  ines_loader #(.PRG_ADDR_W(PRG_W), .CHR_ADDR_W(CHR_W)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .rx_data_in    (rx_data_in),
    .rx_valid_in   (rx_valid_in),
    .rx_ready_out  (rx_ready_out),
    .prg_wr_en_out (prg_wr_en_out),
    .prg_wr_a_out  (prg_wr_a_out),
    .chr_wr_en_out (chr_wr_en_out),
    .chr_wr_a_out  (chr_wr_a_out),
    .wr_d_out      (wr_d_out),
    .mirror_v_out  (mirror_v_out),
    .cart_rst_out  (cart_rst_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .error_out     (error_out),
    .dbg_state_out (dbg_state_out)
  );

  // ---------------- clock ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- write capture ----------------
  logic [PRG_W+7:0] act_prg_q[$];
  logic [CHR_W+7:0] act_chr_q[$];

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (prg_wr_en_out) act_prg_q.push_back({prg_wr_a_out, wr_d_out});
      if (chr_wr_en_out) act_chr_q.push_back({chr_wr_a_out, wr_d_out});
    end
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]       img[$];
  logic [PRG_W+7:0] exp_prg_q[$];
  logic [CHR_W+7:0] exp_chr_q[$];

  typedef struct {
    logic [7:0] b4;
    logic [7:0] b5;
    logic [7:0] b6;
    int         bad_idx;
    logic [7:0] bad_val;
    int         gap_pct;
    int         stop_after;
    bit         exp_done;
    bit         exp_err;
    int         exp_prg;
    int         exp_chr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_ready",    32'(rx_ready_out), 0);
    chk("rst_prg_en",   32'(prg_wr_en_out), 0);
    chk("rst_chr_en",   32'(chr_wr_en_out), 0);
    chk("rst_prg_a",    32'(prg_wr_a_out), 0);
    chk("rst_chr_a",    32'(chr_wr_a_out), 0);
    chk("rst_wr_d",     32'(wr_d_out), 0);
    chk("rst_mirror",   32'(mirror_v_out), 0);
    chk("rst_cart_rst", 32'(cart_rst_out), 1);
    chk("rst_busy",     32'(busy_out), 0);
    chk("rst_done",     32'(done_out), 0);
    chk("rst_error",    32'(error_out), 0);
    chk("rst_state",    32'(dbg_state_out), 32'(ST_IDLE));
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    #1 rst_n_in = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  // Reference: builds the image and the write list the loader must produce from it.
  task automatic build_load(input vec_t v, output int n_acc);
    logic [7:0] magic[4];
    int prg_max, chr_max, toff, n_prg, n_chr, tot;
    bit ok;
    magic[0] = 8'h4E; magic[1] = 8'h45; magic[2] = 8'h53; magic[3] = 8'h1A;
    prg_max = 1 << (PRG_W - 14);
    chr_max = 1 << (CHR_W - 13);
    img.delete(); exp_prg_q.delete(); exp_chr_q.delete();
    for (int k = 0; k < 16; k++) img.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) img[k] = magic[k];
    img[4] = v.b4; img[5] = v.b5; img[6] = v.b6;
    if (v.bad_idx >= 0) img[v.bad_idx] = v.bad_val;
    n_prg = int'(v.b4) * 16384;
    n_chr = int'(v.b5) * 8192;
    toff  = v.b6[2] ? 512 : 0;
    ok = 1'b0;
    if (v.bad_idx >= 0) begin
      n_acc = v.bad_idx + 1; tot = 80;
    end else if (v.b4 == 0 || int'(v.b4) > prg_max || int'(v.b5) > chr_max || (v.b6[2] && !TRN_EN)) begin
      n_acc = 16; tot = 80;
    end else begin
      ok = 1'b1; tot = 16 + toff + n_prg + n_chr; n_acc = tot;
    end
    while (img.size() < tot) img.push_back(8'($urandom));
    if (ok) begin
      for (int a = 0; a < n_prg; a++) exp_prg_q.push_back({PRG_W'(a), img[16 + toff + a]});
      for (int a = 0; a < n_chr; a++) exp_chr_q.push_back({CHR_W'(a), img[16 + toff + n_prg + a]});
    end
  endtask

  task automatic pulse_start();
    chk("busy_before_start", 32'(busy_out), 0);
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    chk("busy_after_start",  32'(busy_out), 1);
    chk("cart_rst_loading",  32'(cart_rst_out), 1);
    chk("done_cleared",      32'(done_out), 0);
    chk("error_cleared",     32'(error_out), 0);
    chk("ready_in_hdr",      32'(rx_ready_out), 1);
  endtask

  // Drives bytes with optional idle gaps; stops when the loader stops accepting.
  task automatic send_stream(input int n_send, input int gap_pct, output int sent);
    int cyc;
    cyc = 0;
    sent = 0;
    while (sent < n_send) begin
      if (cyc > 70000) begin
        chk("send_timeout", 32'(cyc), 0);
        break;
      end
      if (!rx_ready_out) break;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        rx_valid_in = 1'b0;
        @(posedge clk_in);
        #1 cyc++;
        continue;
      end
      rx_data_in  = img[sent];
      rx_valid_in = 1'b1;
      start_in    = (sent == 100);
      @(posedge clk_in);
      #1 start_in = 1'b0;
      cyc++;
      sent++;
    end
    rx_valid_in = 1'b0;
    start_in    = 1'b0;
  endtask

  task automatic compare_writes(input int prg_base, input int chr_base);
    int n;
    n = act_prg_q.size() - prg_base;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (k >= exp_prg_q.size()) begin
        errors++;
        $display("FAIL prg_extra_write idx=%0d got=%0h required=none", k, act_prg_q[prg_base + k]);
        break;
      end
      if (act_prg_q[prg_base + k] !== exp_prg_q[k]) begin
        errors++;
        $display("FAIL prg_write idx=%0d got=%0h required=%0h", k, act_prg_q[prg_base + k], exp_prg_q[k]);
        break;
      end
    end
    n = act_chr_q.size() - chr_base;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (k >= exp_chr_q.size()) begin
        errors++;
        $display("FAIL chr_extra_write idx=%0d got=%0h required=none", k, act_chr_q[chr_base + k]);
        break;
      end
      if (act_chr_q[chr_base + k] !== exp_chr_q[k]) begin
        errors++;
        $display("FAIL chr_write idx=%0d got=%0h required=%0h", k, act_chr_q[chr_base + k], exp_chr_q[k]);
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_acc, n_send, exp_sent, sent, prg_base, chr_base, prg_seen, chr_seen;
    vec_t v;

    //          b4     b5     b6     bad  bval   gap stop  done err  prg    chr
    vecs[0]  = '{8'd1, 8'd1, 8'h01, -1, 8'h00, 0,  0,    1'b1, 1'b0, 16384, 8192};
    vecs[1]  = '{8'd1, 8'd1, 8'h00,  2, 8'h54, 0,  0,    1'b0, 1'b1, 0,     0};
    vecs[2]  = '{8'd3, 8'd1, 8'h00, -1, 8'h00, 0,  0,    1'b0, 1'b1, 0,     0};
    vecs[3]  = '{8'd2, 8'd0, 8'h00, -1, 8'h00, 0,  0,    1'b1, 1'b0, 32768, 0};
`ifdef INES_TRAINER_SKIP_EN
    vecs[4]  = '{8'd1, 8'd0, 8'h04, -1, 8'h00, 0,  592,  1'b0, 1'b0, 64,    0};
`else
    vecs[4]  = '{8'd1, 8'd0, 8'h04, -1, 8'h00, 0,  592,  1'b0, 1'b1, 0,     0};
`endif
    vecs[5]  = '{8'd1, 8'd1, 8'h01, -1, 8'h00, 30, 3016, 1'b0, 1'b0, 3000,  0};
    vecs[6]  = '{8'd1, 8'd0, 8'h00, -1, 8'h00, 10, 0,    1'b1, 1'b0, 16384, 0};
    vecs[7]  = '{8'd0, 8'd1, 8'h00, -1, 8'h00, 0,  0,    1'b0, 1'b1, 0,     0};
    vecs[8]  = '{8'd1, 8'd2, 8'h00, -1, 8'h00, 0,  0,    1'b0, 1'b1, 0,     0};
    vecs[9]  = '{8'd1, 8'd1, 8'h00,  0, 8'h4F, 0,  0,    1'b0, 1'b1, 0,     0};
    vecs[10] = '{8'd1, 8'd1, 8'h00,  3, 8'h1B, 0,  0,    1'b0, 1'b1, 0,     0};

    // ---------------- reset ----------------
    rst_n_in    = 1'b1;
    start_in    = 1'b0;
    rx_data_in  = 8'd0;
    rx_valid_in = 1'b0;
    #2 rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 check_reset_vals();
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1 check_reset_vals();

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      build_load(v, n_acc);
      n_send   = (v.stop_after > 0) ? v.stop_after : img.size();
      exp_sent = (n_send < n_acc) ? n_send : n_acc;
      prg_base = act_prg_q.size();
      chr_base = act_chr_q.size();

      pulse_start();
      send_stream(n_send, v.gap_pct, sent);

      if (v.exp_done && sent == img.size()) begin
        chk("last_strobe", 32'(v.exp_chr > 0 ? chr_wr_en_out : prg_wr_en_out), 1);
        chk("done_with_last_strobe", 32'(done_out), 1);
        chk("cart_rst_off_with_last_strobe", 32'(cart_rst_out), 0);
      end
      if (v.exp_err) chk("error_cycle_after_byte", 32'(error_out), 1);

      repeat (2) @(negedge clk_in);
      chk("bytes_accepted", 32'(sent), 32'(exp_sent));
      chk("done_out",  32'(done_out), 32'(v.exp_done));
      chk("error_out", 32'(error_out), 32'(v.exp_err));
      chk("busy_out",  32'(busy_out), 32'(!(v.exp_done || v.exp_err)));
      chk("rx_ready",  32'(rx_ready_out), 32'(!(v.exp_done || v.exp_err)));
      chk("cart_rst",  32'(cart_rst_out), 32'(!v.exp_done));
      if (v.bad_idx < 0) chk("mirror_v", 32'(mirror_v_out), 32'(v.b6[0]));

      prg_seen = act_prg_q.size() - prg_base;
      chr_seen = act_chr_q.size() - chr_base;
      chk("prg_write_count", 32'(prg_seen), 32'(v.exp_prg));
      chk("chr_write_count", 32'(chr_seen), 32'(v.exp_chr));
      compare_writes(prg_base, chr_base);
      if (v.b6[2] && prg_seen > 0) chk("trn_first_prg_byte", 32'(act_prg_q[prg_base][7:0]), 32'(img[528]));

      if (v.stop_after > 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
